mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: ACCESS cycles without bus_ack before the access is abandoned.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 addr  input  32  byte address, the ALU result.
REQ-005 wdata  input  32  store data, register rt.
REQ-006 mem_read  input  1  load request.
REQ-007 mem_write  input  1  store request.
REQ-008 size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 load_signed  input  1  load result is sign-extended (1) or zero-extended (0).
REQ-010 bus_req  output  1  bus request.
REQ-011 bus_we  output  1  bus write enable.
REQ-012 bus_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-013 bus_be  output  4  byte enables, bit k = byte lane k (little-endian).
REQ-014 bus_wdata  output  32  lane-replicated store data.
REQ-015 bus_rdata  input  32  bus read data, valid with bus_ack.
REQ-016 bus_ack  input  1  bus completion.
REQ-017 rdata  output  32  extracted load result.
REQ-018 stall  output  1  holds the CPU PC and register write.
REQ-019 done  output  1  one-cycle completion pulse.
REQ-020 err_align  output  1  misaligned or reserved-size request.
REQ-021 err_timeout  output  1  access abandoned on timeout.

Function
REQ-022 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-023 A request SHALL be valid in IDLE only, when mem_read|mem_write is high; requests in ACCESS or DONE SHALL be ignored.
REQ-024 Alignment: byte is always aligned; half requires addr[0]=0; word requires addr[1:0]=00; size=11 is never aligned.
REQ-025 Valid aligned request in IDLE: latch bus_addr/bus_we/bus_be/bus_wdata; go to ACCESS next cycle.
REQ-026 Valid misaligned request in IDLE: err_align=1 combinationally that cycle; no bus access; stall=0; state stays IDLE.
REQ-027 mem_read and mem_write both high: treated as a write.
REQ-028 bus_req SHALL be 1 exactly while in ACCESS; bus outputs held stable throughout ACCESS.
REQ-029 Byte enables: byte -> one-hot at addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111.
REQ-030 bus_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-031 ACCESS with bus_ack=1: on a read, register the lane selected by addr[1:0], extended per load_signed, into rdata; go to DONE.
REQ-032 A 4-bit timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-033 Counter reaches TIMEOUT with no ack: go to DONE; rdata=0; err_timeout=1 during DONE.
REQ-034 bus_ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
REQ-035 stall SHALL be 1 in ACCESS, and in IDLE when an aligned request is presented; 0 otherwise.
REQ-036 DONE: done=1, stall=0; unconditionally return to IDLE next cycle.
REQ-037 Minimum latency, accept to done, SHALL be 2 cycles (ack in first ACCESS cycle).
REQ-038 rdata SHALL hold its value until the next completed read or reset; writes leave rdata unchanged.
REQ-039 bus_ack outside ACCESS SHALL be ignored.

Reset
REQ-040 rst_n=0 SHALL immediately force IDLE and zero every output and register, including bus_req.
REQ-041 Reset during ACCESS: the access is dropped with no done pulse.

Verification
REQ-042 Word load: addr=0x100, size=10, bus_rdata=0xDEADBEEF with ack in 3rd ACCESS cycle -> bus_addr=0x100, be=1111, done 4 cycles after accept, rdata=0xDEADBEEF.
REQ-043 Signed byte load: addr=0x103, size=00, load_signed=1, bus_rdata=0x80123456 -> be=1000, rdata=0xFFFFFF80; same with load_signed=0 -> 0x00000080.
REQ-044 Half store: addr=0x202, wdata=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, done one cycle after ack.
REQ-045 Misaligned: word at addr=0x101 -> err_align=1 that cycle, bus_req never asserted, stall=0.
REQ-046 No ack: read held TIMEOUT=15 cycles -> done with err_timeout=1, rdata=0; ack on 15th cycle -> normal completion, no error.
REQ-047 Reset mid-ACCESS: rst_n low 1 cycle -> bus_req and stall drop immediately; no done pulse; next request is accepted normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Word-bus link between the memory stage and the data memory/bus fabric.
// The stage is master; the memory side returns read data qualified by bus_ack.
interface mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage.sv
// CPU memory stage: turns byte/half/word loads and stores into word-bus accesses,
// extracts and extends load data, and abandons an access after TIMEOUT unacked cycles.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  mem_stage_if.master bus,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [3:0]  cnt_q;
  logic        tout_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        aligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        accept;
  logic        ack_hit;
  logic        to_hit;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_ext;

  assign req = mem_read | mem_write;

  always_comb begin
    aligned = 1'b0;
    be_c    = 4'b0000;
    wdata_c = wdata;
    case (size)
      2'b00: begin
        aligned = 1'b1;
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~addr[0];
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      2'b10: begin
        aligned = (addr[1:0] == 2'b00);
        be_c    = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (req && aligned) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // An ack arriving on the final allowed cycle still completes normally.
        if (bus.bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (cnt_q == CNT_LAST) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lane8  = bus.bus_rdata[{off_q, 3'b000} +: 8];
    lane16 = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & lane8[7]}}, lane8};
      2'b01:   load_ext = {{16{sign_q & lane16[15]}}, lane16};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= mem_write;
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wdata_c;
        off_q   <= addr[1:0];
        size_q  <= size;
        sign_q  <= load_signed;
        cnt_q   <= '0;
        tout_q  <= 1'b0;
      end
      if (ack_hit) begin
        if (!we_q) rdata_q <= load_ext;
      end else if (to_hit) begin
        tout_q <= 1'b1;
        if (!we_q) rdata_q <= '0;
      end else if (state == ACCESS) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign bus.bus_req   = (state == ACCESS);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  // Request decode is combinational, so gate it off while reset is held.
  assign err_align   = rst_n && (state == IDLE) && req && !aligned;
  assign stall       = (state == ACCESS) || (rst_n && (state == IDLE) && req && aligned);
  assign done        = (state == DONE);
  assign err_timeout = (state == DONE) && tout_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected load results/latencies,
// checked with immediate assertions when the done pulse appears.
module tb_mem_stage;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_signed = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err_align;
  logic        err_timeout;

  mem_stage_if bus_if ();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .wdata       (wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .load_signed (load_signed),
    .bus         (bus_if),
    .rdata       (rdata),
    .stall       (stall),
    .done        (done),
    .err_align   (err_align),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        terr;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                         input int ack_n, input logic [31:0] brd, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd, input logic eto);
    exp_t e;
    exp_t got_e;
    bit   got;
    int   lat;
    e.rdata = erd;
    e.terr  = eto;
    e.lat   = (ack_n > 0) ? ack_n + 1 : TIMEOUT + 1;
    addr = a; wdata = wd; mem_read = rd; mem_write = wr; size = sz; load_signed = sgn;
    #1;
    chk({tag, "_stall_on_req"}, stall, 1);
    chk({tag, "_no_align_err"}, err_align, 0);
    sb.push_back(e);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; wdata = $urandom; load_signed = ~sgn;
    got = 0;
    lat = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      chk({tag, "_bus_req"}, bus_if.bus_req, 1);
      chk({tag, "_bus_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
      chk({tag, "_stall_access"}, stall, 1);
      if (n == 1) begin
        chk({tag, "_bus_be"}, bus_if.bus_be, ebe);
        chk({tag, "_bus_we"}, bus_if.bus_we, wr);
        chk({tag, "_bus_wdata"}, bus_if.bus_wdata, ewd);
      end
      if (n == ack_n) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = brd;
      end else begin
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h5A5A_5A5A;
      end
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      #1;
      if (done) begin
        got = 1;
        lat = n + 1;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      got_e = sb.pop_front();
      chk({tag, "_rdata"}, rdata, got_e.rdata);
      chk({tag, "_err_timeout"}, err_timeout, got_e.terr);
      chk({tag, "_latency"}, lat, got_e.lat);
      chk({tag, "_stall_done"}, stall, 0);
      chk({tag, "_req_done"}, bus_if.bus_req, 0);
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;
    // Reset with a reserved-size request present: every output must stay zero.
    mem_read = 1'b1; size = 2'b11; addr = 32'h0000_0001;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_bus_req", bus_if.bus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_err_align", err_align, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_addr", bus_if.bus_addr, 0);
    chk("rst_bus_be", bus_if.bus_be, 0);
    chk("rst_bus_we", bus_if.bus_we, 0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("word_ld", 32'h100, 32'h0, 1, 0, 2'b10, 0, 3, 32'hDEAD_BEEF,
            4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
    run_txn("sbyte_ld", 32'h103, 32'h0, 1, 0, 2'b00, 1, 1, 32'h8012_3456,
            4'b1000, 32'h0, 32'hFFFF_FF80, 0);
    run_txn("ubyte_ld", 32'h103, 32'h0, 1, 0, 2'b00, 0, 1, 32'h8012_3456,
            4'b1000, 32'h0, 32'h0000_0080, 0);
    run_txn("half_st", 32'h202, 32'h0000_ABCD, 0, 1, 2'b01, 0, 2, 32'hFFFF_FFFF,
            4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 0);
    run_txn("rdwr_st", 32'h301, 32'h0000_00C3, 1, 1, 2'b00, 0, 1, 32'h1234_5678,
            4'b0010, 32'hC3C3_C3C3, 32'h0000_0080, 0);

    // Ack while idle must be ignored.
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("idle_ack_rdata", rdata, 32'h0000_0080);
    chk("idle_ack_done", done, 0);
    chk("idle_ack_req", bus_if.bus_req, 0);

    // Misaligned word, misaligned half and reserved size.
    @(negedge clk);
    addr = 32'h101; size = 2'b10; mem_read = 1'b1;
    #1;
    chk("mis_word_err", err_align, 1);
    chk("mis_word_stall", stall, 0);
    @(negedge clk);
    addr = 32'h103; size = 2'b01;
    #1;
    chk("mis_half_err", err_align, 1);
    chk("mis_word_no_req", bus_if.bus_req, 0);
    @(negedge clk);
    addr = 32'h100; size = 2'b11;
    #1;
    chk("rsv_size_err", err_align, 1);
    chk("mis_half_no_req", bus_if.bus_req, 0);
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    chk("mis_no_req", bus_if.bus_req, 0);
    chk("mis_no_done", done, 0);
    chk("mis_err_clear", err_align, 0);
    @(negedge clk);

    run_txn("timeout_ld", 32'h104, 32'h0, 1, 0, 2'b10, 0, 0, 32'h0,
            4'b1111, 32'h0, 32'h0, 1);
    run_txn("ack_last_ld", 32'h108, 32'h0, 1, 0, 2'b10, 0, TIMEOUT, 32'h1234_5678,
            4'b1111, 32'h0, 32'h1234_5678, 0);

    // Reset in the middle of an access.
    addr = 32'h110; size = 2'b10; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_before", bus_if.bus_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus_if.bus_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
    end

    run_txn("shalf_ld", 32'h10A, 32'h0, 1, 0, 2'b01, 1, 1, 32'h8001_7FFF,
            4'b1100, 32'h0, 32'hFFFF_8001, 0);
    run_txn("uhalf_ld", 32'h10C, 32'h0, 1, 0, 2'b01, 0, 2, 32'h0000_F00D,
            4'b0011, 32'h0, 32'h0000_F00D, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
